spi_master_multi_cs: RTL and testbench

Parametrised SPI master with integrated multi-target chip-select control. It is the successor to the single-CS, byte-only master. Adds configurable word width, N chip-select lines, per-frame runtime SPI mode, per-frame bit order and multi-word frames with a programmable CS-inactive gap. Sits between on-chip peripheral drivers (display, IMU, flash) and the board SPI bus.

---
 rtl/spi_master_multi_cs_if.sv | 34 +++
 rtl/spi_master_multi_cs.sv | 201 ++++++++++++++++++++
 tb/tb_spi_master_multi_cs.sv | 351 +++++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/spi_master_multi_cs_if.sv
// Word-level request/response bundle between a peripheral driver
// and the multi-CS SPI master.
interface spi_master_multi_cs_if #(
    parameter int WORD_WIDTH       = 8,
    parameter int NUM_CS           = 4,
    parameter int MAX_WORDS_PER_CS = 2
);
    localparam int CW  = $clog2(MAX_WORDS_PER_CS + 1);
    localparam int CSW = (NUM_CS > 1) ? $clog2(NUM_CS) : 1;

    logic [CW-1:0]         i_tx_count;
    logic [CSW-1:0]        i_cs_sel;
    logic [1:0]            i_spi_mode;
    logic                  i_lsb_first;
    logic [WORD_WIDTH-1:0] i_tx_word;
    logic                  i_tx_dv;
    logic                  o_tx_ready;
    logic                  o_busy;
    logic [WORD_WIDTH-1:0] o_rx_word;
    logic                  o_rx_dv;
    logic [CW-1:0]         o_rx_count;

    modport master (
        output i_tx_count, i_cs_sel, i_spi_mode, i_lsb_first,
        output i_tx_word, i_tx_dv,
        input  o_tx_ready, o_busy, o_rx_word, o_rx_dv, o_rx_count
    );

    modport slave (
        input  i_tx_count, i_cs_sel, i_spi_mode, i_lsb_first,
        input  i_tx_word, i_tx_dv,
        output o_tx_ready, o_busy, o_rx_word, o_rx_dv, o_rx_count
    );
endinterface

// File: rtl/spi_master_multi_cs.sv
// SPI master with N active-low chip selects, runtime mode/bit order
// and multi-word CS-low frames followed by a CS-inactive gap.
module spi_master_multi_cs #(
    parameter int WORD_WIDTH        = 8,
    parameter int NUM_CS            = 4,
    parameter int CLKS_PER_HALF_BIT = 4,
    parameter int MAX_WORDS_PER_CS  = 2,
    parameter int CS_INACTIVE_CLKS  = 10,
    parameter int DEFAULT_SPI_MODE  = 3
) (
    input  logic              clk,
    input  logic              rst,
    spi_master_multi_cs_if.slave bus,
    output logic              SCK,
    output logic              MOSI,
    input  logic              MISO,
    output logic [NUM_CS-1:0] CS_L
);
    localparam int CW    = $clog2(MAX_WORDS_PER_CS + 1);
    localparam int HW    = $clog2(CLKS_PER_HALF_BIT) + 1;
    localparam int EDGES = 2 * WORD_WIDTH;
    localparam int EW    = $clog2(EDGES + 1);
    localparam int GW    = $clog2(CS_INACTIVE_CLKS + 1) + 1;
    localparam logic [1:0] DEF_MODE = 2'(DEFAULT_SPI_MODE);

    typedef enum logic [1:0] {
        IDLE,
        SHIFT,
        WAIT_WORD,
        CS_GAP
    } state_t;

    state_t                r_state;
    state_t                w_state_nxt;
    logic [HW-1:0]         r_clk_cnt;
    logic [EW-1:0]         r_edge_cnt;
    logic [GW-1:0]         r_gap;
    logic [1:0]            r_mode;
    logic                  r_lsb;
    logic [CW-1:0]         r_words;
    logic [CW-1:0]         r_word_idx;
    logic [WORD_WIDTH-1:0] r_tx_sr;
    logic [WORD_WIDTH-1:0] r_rx_sr;
    logic [WORD_WIDTH-1:0] r_rx_word;
    logic                  r_rx_dv;
    logic [CW-1:0]         r_rx_count;
    logic                  r_sck;
    logic                  r_mosi;
    logic [NUM_CS-1:0]     r_cs_l;

    logic                  w_accept;
    logic                  w_edge;
    logic                  w_fire;
    logic                  w_last;
    logic                  w_lead;
    logic                  w_shift;
    logic                  w_cpha;
    logic                  w_lsb;
    logic                  w_first_bit;
    logic [CW-1:0]         w_words;
    logic [NUM_CS-1:0]     w_cs_dec;

    // First-word fields come straight from the bus; later words reuse the latch
    assign w_cpha = (r_state == IDLE) ? bus.i_spi_mode[0] : r_mode[0];
    assign w_lsb  = (r_state == IDLE) ? bus.i_lsb_first   : r_lsb;
    assign w_first_bit = w_lsb ? bus.i_tx_word[0]
                               : bus.i_tx_word[WORD_WIDTH-1];
    assign w_last  = (r_word_idx == r_words - CW'(1));
    assign w_lead  = (r_sck == r_mode[1]);
    assign w_shift = (w_lead == r_mode[0]);

    always_comb begin
        w_words = bus.i_tx_count;
        if (bus.i_tx_count == '0)
            w_words = CW'(1);
        else if (bus.i_tx_count > CW'(MAX_WORDS_PER_CS))
            w_words = CW'(MAX_WORDS_PER_CS);
    end

    // Out-of-range selects leave every CS high
    always_comb begin
        w_cs_dec = '1;
        for (int i = 0; i < NUM_CS; i++)
            if (int'(bus.i_cs_sel) == i)
                w_cs_dec[i] = 1'b0;
    end

    always_ff @(posedge clk) begin
        if (rst)
            r_state <= IDLE;
        else
            r_state <= w_state_nxt;
    end

    always_comb begin
        w_state_nxt = r_state;
        w_accept    = 1'b0;
        w_edge      = 1'b0;
        w_fire      = 1'b0;
        unique case (r_state)
            IDLE, WAIT_WORD: begin
                if (bus.i_tx_dv) begin
                    w_accept    = 1'b1;
                    w_state_nxt = SHIFT;
                end
            end
            SHIFT: begin
                if (r_edge_cnt == EW'(EDGES)) begin
                    if (r_clk_cnt == HW'(1)) begin
                        w_fire      = 1'b1;
                        w_state_nxt = w_last ? CS_GAP : WAIT_WORD;
                    end
                end else if (r_clk_cnt == HW'(CLKS_PER_HALF_BIT - 1)) begin
                    w_edge = 1'b1;
                end
            end
            CS_GAP: begin
                if (r_gap == GW'(CS_INACTIVE_CLKS))
                    w_state_nxt = IDLE;
            end
            default: w_state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_clk_cnt  <= '0;
            r_edge_cnt <= '0;
            r_gap      <= '0;
            r_mode     <= DEF_MODE;
            r_lsb      <= 1'b0;
            r_words    <= '0;
            r_word_idx <= '0;
            r_tx_sr    <= '0;
            r_rx_sr    <= '0;
            r_rx_word  <= '0;
            r_rx_dv    <= 1'b0;
            r_rx_count <= '0;
            r_sck      <= DEF_MODE[1];
            r_mosi     <= 1'b0;
            r_cs_l     <= '1;
        end else begin
            r_rx_dv <= 1'b0;
            if (w_accept) begin
                r_clk_cnt  <= '0;
                r_edge_cnt <= '0;
                if (!w_cpha) begin
                    r_mosi  <= w_first_bit;
                    r_tx_sr <= w_lsb ? (bus.i_tx_word >> 1)
                                     : (bus.i_tx_word << 1);
                end else begin
                    r_tx_sr <= bus.i_tx_word;
                end
                if (r_state == IDLE) begin
                    r_mode     <= bus.i_spi_mode;
                    r_lsb      <= bus.i_lsb_first;
                    r_words    <= w_words;
                    r_word_idx <= '0;
                    r_sck      <= bus.i_spi_mode[1];
                    r_cs_l     <= w_cs_dec;
                end
            end else if (r_state == SHIFT) begin
                if (w_edge) begin
                    r_clk_cnt  <= '0;
                    r_edge_cnt <= r_edge_cnt + 1'b1;
                    r_sck      <= ~r_sck;
                    if (w_shift) begin
                        r_mosi  <= r_lsb ? r_tx_sr[0]
                                         : r_tx_sr[WORD_WIDTH-1];
                        r_tx_sr <= r_lsb ? (r_tx_sr >> 1) : (r_tx_sr << 1);
                    end else begin
                        r_rx_sr <= r_lsb
                            ? {MISO, r_rx_sr[WORD_WIDTH-1:1]}
                            : {r_rx_sr[WORD_WIDTH-2:0], MISO};
                    end
                end else begin
                    r_clk_cnt <= r_clk_cnt + 1'b1;
                end
                if (w_fire) begin
                    r_rx_dv    <= 1'b1;
                    r_rx_word  <= r_rx_sr;
                    r_rx_count <= r_word_idx;
                    r_word_idx <= r_word_idx + 1'b1;
                    r_gap      <= '0;
                end
            end else if (r_state == CS_GAP) begin
                r_cs_l <= '1;
                r_gap  <= r_gap + 1'b1;
            end
        end
    end

    assign bus.o_tx_ready = (r_state == IDLE) || (r_state == WAIT_WORD);
    assign bus.o_busy     = (r_state != IDLE);
    assign bus.o_rx_word  = r_rx_word;
    assign bus.o_rx_dv    = r_rx_dv;
    assign bus.o_rx_count = r_rx_count;
    assign SCK            = r_sck;
    assign MOSI           = r_mosi;
    assign CS_L           = r_cs_l;
endmodule

// File: tb/tb_spi_master_multi_cs.sv
// Scoreboard bench for spi_master_multi_cs: an 8-bit default instance
// plus a 16-bit instance, each with a small SPI slave model.
module tb_spi_master_multi_cs;
    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int n_cmp = 0;
    int n_err = 0;

    typedef struct {
        logic [31:0] w;
        int          idx;
    } exp_t;
    exp_t q0[$];
    exp_t q1[$];

    spi_master_multi_cs_if #(.WORD_WIDTH(8), .NUM_CS(4),
                             .MAX_WORDS_PER_CS(2)) b0();
    spi_master_multi_cs_if #(.WORD_WIDTH(16), .NUM_CS(4),
                             .MAX_WORDS_PER_CS(2)) b1();

    logic       sck0, mosi0, miso0;
    logic       sck1, mosi1, miso1;
    logic [3:0] csl0, csl1;
    logic       lb0 = 1'b1;
    logic       s_miso0 = 1'b0;

    assign miso0 = lb0 ? mosi0 : s_miso0;
    assign miso1 = mosi1;

    spi_master_multi_cs #(.WORD_WIDTH(8)) dut0 (
        .clk(clk), .rst(rst), .bus(b0),
        .SCK(sck0), .MOSI(mosi0), .MISO(miso0), .CS_L(csl0)
    );
    spi_master_multi_cs #(.WORD_WIDTH(16)) dut1 (
        .clk(clk), .rst(rst), .bus(b1),
        .SCK(sck1), .MOSI(mosi1), .MISO(miso1), .CS_L(csl1)
    );

    task automatic chk(input string nm, input logic [63:0] act,
                       input logic [63:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", nm, act, exp);
        end
    endtask

    // Scoreboard monitors
    int rx_n0 = 0, rx_cyc0 = 0, rx_n1 = 0;
    always @(negedge clk) begin
        exp_t e;
        if (b0.o_rx_dv) begin
            rx_n0++;
            rx_cyc0 = cyc;
            if (q0.size() == 0) begin
                chk("rx0_unexpected", b0.o_rx_word, 64'hDEAD);
            end else begin
                e = q0.pop_front();
                chk("rx0_word", b0.o_rx_word, e.w);
                chk("rx0_count", b0.o_rx_count, e.idx);
            end
        end
        if (b1.o_rx_dv) begin
            rx_n1++;
            if (q1.size() == 0) begin
                chk("rx1_unexpected", b1.o_rx_word, 64'hDEAD);
            end else begin
                e = q1.pop_front();
                chk("rx1_word", b1.o_rx_word, e.w);
                chk("rx1_count", b1.o_rx_count, e.idx);
            end
        end
    end

    // Chip-select watch
    int         multi_low = 0;
    int         cs_falls = 0;
    logic [3:0] cs_seen = '0;
    logic       prev_hi = 1'b1;
    always @(negedge clk) begin
        if ($countones(~csl0) > 1 || $countones(~csl1) > 1)
            multi_low++;
        if (prev_hi && !(&csl0))
            cs_falls++;
        prev_hi = &csl0;
        cs_seen = cs_seen | ~csl0;
    end

    // Slave model on dut0
    logic [1:0] sl_mode0 = 2'b00;
    logic       sl_lsb0 = 1'b0;
    logic [7:0] sl_data0 = '0;
    logic [7:0] s_tx0 = '0;
    logic [7:0] sl_rx0 = '0;
    int         sl_edges0 = 0;
    logic [3:0] sl_csp0 = 4'hF;
    logic       sl_sckp0 = 1'b1;
    always @(sck0 or csl0) begin
        if (csl0 !== sl_csp0) begin
            if (&sl_csp0 && !(&csl0)) begin
                s_tx0 = sl_data0;
                sl_rx0 = '0;
                sl_edges0 = 0;
                if (!sl_mode0[0]) begin
                    s_miso0 = sl_lsb0 ? s_tx0[0] : s_tx0[7];
                    s_tx0 = sl_lsb0 ? (s_tx0 >> 1) : (s_tx0 << 1);
                end
            end
            sl_csp0 = csl0;
        end
        if (sck0 !== sl_sckp0) begin
            if (!(&csl0) && !(sl_edges0 == 0 && sck0 == sl_mode0[1])) begin
                sl_edges0++;
                if ((sck0 != sl_mode0[1]) ^ sl_mode0[0]) begin
                    sl_rx0 = sl_lsb0 ? {mosi0, sl_rx0[7:1]}
                                     : {sl_rx0[6:0], mosi0};
                end else begin
                    s_miso0 = sl_lsb0 ? s_tx0[0] : s_tx0[7];
                    s_tx0 = sl_lsb0 ? (s_tx0 >> 1) : (s_tx0 << 1);
                end
            end
            sl_sckp0 = sck0;
        end
    end

    // Capture-only slave on dut1, MSB first
    logic [1:0]  sl_mode1 = 2'b01;
    logic [15:0] sl_rx1 = '0;
    int          sl_edges1 = 0;
    logic [3:0]  sl_csp1 = 4'hF;
    logic        sl_sckp1 = 1'b1;
    always @(sck1 or csl1) begin
        if (csl1 !== sl_csp1) begin
            if (&sl_csp1 && !(&csl1)) begin
                sl_rx1 = '0;
                sl_edges1 = 0;
            end
            sl_csp1 = csl1;
        end
        if (sck1 !== sl_sckp1) begin
            if (!(&csl1) && !(sl_edges1 == 0 && sck1 == sl_mode1[1])) begin
                sl_edges1++;
                if ((sck1 != sl_mode1[1]) ^ sl_mode1[0])
                    sl_rx1 = {sl_rx1[14:0], mosi1};
            end
            sl_sckp1 = sck1;
        end
    end

    int t_acc0 = 0;

    task automatic wait_ready0();
        int i = 0;
        @(negedge clk);
        while (!b0.o_tx_ready && i < 3000) begin
            @(negedge clk);
            i++;
        end
        chk("ready0_wait", b0.o_tx_ready, 1);
    endtask

    task automatic wait_idle0();
        int i = 0;
        @(negedge clk);
        while (b0.o_busy && i < 3000) begin
            @(negedge clk);
            i++;
        end
        chk("idle0_wait", b0.o_busy, 0);
    endtask

    task automatic wait_rx0(input int n);
        int i = 0;
        do begin
            @(negedge clk);
            #1;
            i++;
        end while (rx_n0 < n && i < 3000);
        chk("rx0_wait", rx_n0 >= n, 1);
    endtask

    task automatic send0(input logic [7:0] w, input int cnt, input int cs,
                         input logic [1:0] m, input logic lsb);
        wait_ready0();
        b0.i_tx_word   = w;
        b0.i_tx_count  = 2'(cnt);
        b0.i_cs_sel    = 2'(cs);
        b0.i_spi_mode  = m;
        b0.i_lsb_first = lsb;
        b0.i_tx_dv     = 1'b1;
        @(negedge clk);
        t_acc0 = cyc;
        b0.i_tx_dv = 1'b0;
    endtask

    task automatic pulse0(input logic [7:0] w, input string nm);
        chk(nm, b0.o_tx_ready, 0);
        b0.i_tx_word = w;
        b0.i_tx_dv = 1'b1;
        @(negedge clk);
        b0.i_tx_dv = 1'b0;
    endtask

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin
        int base, gap, bad, i;
        b0.i_tx_word = '0; b0.i_tx_count = '0; b0.i_cs_sel = '0;
        b0.i_spi_mode = '0; b0.i_lsb_first = 1'b0; b0.i_tx_dv = 1'b0;
        b1.i_tx_word = '0; b1.i_tx_count = '0; b1.i_cs_sel = '0;
        b1.i_spi_mode = '0; b1.i_lsb_first = 1'b0; b1.i_tx_dv = 1'b0;

        repeat (3) @(negedge clk);
        chk("rst_cs", csl0, 4'hF);
        chk("rst_sck", sck0, 1);
        chk("rst_mosi", mosi0, 0);
        chk("rst_ready", b0.o_tx_ready, 1);
        chk("rst_busy", b0.o_busy, 0);
        chk("rst_rx_dv", b0.o_rx_dv, 0);
        chk("rst_rx_word", b0.o_rx_word, 0);
        chk("rst_rx_count", b0.o_rx_count, 0);
        rst = 1'b0;
        repeat (2) @(negedge clk);

        // Two-word loopback frame, mode 3, CS1
        cs_seen = '0;
        cs_falls = 0;
        lb0 = 1'b1;
        base = rx_n0;
        q0.push_back('{32'h37, 0});
        send0(8'h37, 2, 1, 2'b11, 1'b0);
        q0.push_back('{32'h38, 1});
        send0(8'h38, 2, 1, 2'b11, 1'b0);
        wait_rx0(base + 2);
        gap = 0;
        i = 0;
        do begin
            @(negedge clk);
            if (b0.o_busy && &csl0) gap++;
            i++;
        end while (b0.o_busy && i < 200);
        chk("t1_gap_ge10", gap >= 10, 1);
        chk("t1_cs_seen", cs_seen, 4'b0010);
        chk("t1_cs_windows", cs_falls, 1);

        // Mode 0, LSB first, slave returns 0xA5
        lb0 = 1'b0;
        sl_mode0 = 2'b00;
        sl_lsb0 = 1'b1;
        sl_data0 = 8'hA5;
        base = rx_n0;
        q0.push_back('{32'hA5, 0});
        send0(8'h1E, 1, 0, 2'b00, 1'b1);
        chk("t2_sck_idle_start", sck0, 0);
        wait_rx0(base + 1);
        chk("t2_latency", rx_cyc0 - t_acc0, 66);
        wait_idle0();
        chk("t2_mosi_lsb_first", sl_rx0, 8'h1E);
        chk("t2_sck_idle_end", sck0, 0);
        lb0 = 1'b1;

        // 16-bit word, mode 1, loopback
        q1.push_back('{32'hBEEF, 0});
        @(negedge clk);
        b1.i_tx_word = 16'hBEEF; b1.i_tx_count = 2'd1;
        b1.i_cs_sel = 2'd2; b1.i_spi_mode = 2'b01;
        b1.i_lsb_first = 1'b0; b1.i_tx_dv = 1'b1;
        @(negedge clk);
        b1.i_tx_dv = 1'b0;
        i = 0;
        while ((rx_n1 < 1 || b1.o_busy) && i < 3000) begin
            @(negedge clk);
            i++;
        end
        chk("t3_done", rx_n1 == 1 && !b1.o_busy, 1);
        chk("t3_edges", sl_edges1, 32);
        chk("t3_slave_rx", sl_rx1, 16'hBEEF);

        // Ignored strobes and count clipping
        base = rx_n0;
        q0.push_back('{32'h11, 0});
        send0(8'h11, 3, 2, 2'b11, 1'b0);
        repeat (10) @(negedge clk);
        pulse0(8'h99, "t4_ready_low_shift");
        q0.push_back('{32'h22, 1});
        send0(8'h22, 3, 2, 2'b11, 1'b0);
        wait_rx0(base + 2);
        pulse0(8'h77, "t4_ready_low_gap");
        wait_idle0();
        repeat (150) @(negedge clk);
        chk("t4_rx_total", rx_n0 - base, 2);
        chk("t4_idle_after_clip", b0.o_busy, 0);

        // Reset in word 1, bit 3
        base = rx_n0;
        q0.push_back('{32'hC3, 0});
        send0(8'hC3, 2, 3, 2'b00, 1'b0);
        wait_rx0(base + 1);
        send0(8'h44, 2, 3, 2'b00, 1'b0);
        repeat (26) @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        chk("t5_cs", csl0, 4'hF);
        chk("t5_sck", sck0, 1);
        chk("t5_ready", b0.o_tx_ready, 1);
        chk("t5_rx_dv", b0.o_rx_dv, 0);
        rst = 1'b0;
        repeat (100) @(negedge clk);
        chk("t5_no_partial_rx", rx_n0 - base, 1);
        q0.push_back('{32'h5A, 0});
        send0(8'h5A, 1, 0, 2'b11, 1'b0);
        wait_rx0(base + 2);
        wait_idle0();

        // Back-to-back frames, CS0 mode 0 then CS3 mode 3
        base = rx_n0;
        q0.push_back('{32'h81, 0});
        send0(8'h81, 1, 0, 2'b00, 1'b0);
        wait_rx0(base + 1);
        bad = 0;
        i = 0;
        while (b0.o_busy && i < 200) begin
            if (sck0 !== 1'b0) bad++;
            @(negedge clk);
            i++;
        end
        chk("t6_sck_hold_in_gap", bad, 0);
        q0.push_back('{32'h7E, 0});
        send0(8'h7E, 1, 3, 2'b11, 1'b0);
        chk("t6_sck_new_idle", sck0, 1);
        chk("t6_cs3", csl0, 4'b0111);
        wait_rx0(base + 2);
        wait_idle0();

        chk("never_two_cs_low", multi_low, 0);
        chk("q0_drained", q0.size(), 0);
        chk("q1_drained", q1.size(), 0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***",
                 n_cmp, n_err);
        $finish;
    end
endmodule
